// File: rtl/exc_entry_unit.sv
// Exception/interrupt entry and ertn return unit at WB: owns CRMD/PRMD/ERA/EENTRY/ESTAT.Ecode/ESUB,
// sequences flush -> redirect after every accepted event.
module exc_entry_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic [5:0]  int_cause,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_ecode,
  input  logic        wb_ertn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        mie,
  output logic        in_exception,
  output logic        flush,
  output logic        ertn_commit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned CSRN_W  = 14;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned EENT_W  = XLEN - 6;

  localparam logic [CSRN_W-1:0] CSR_CRMD   = CSRN_W'(14'h0);
  localparam logic [CSRN_W-1:0] CSR_PRMD   = CSRN_W'(14'h1);
  localparam logic [CSRN_W-1:0] CSR_ESTAT  = CSRN_W'(14'h5);
  localparam logic [CSRN_W-1:0] CSR_ERA    = CSRN_W'(14'h6);
  localparam logic [CSRN_W-1:0] CSR_ESUB   = CSRN_W'(14'h7);
  localparam logic [CSRN_W-1:0] CSR_EENTRY = CSRN_W'(14'hC);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           plv_q, plv_d;
  logic                 ie_q, ie_d;
  logic [1:0]           pplv_q, pplv_d;
  logic                 pie_q, pie_d;
  logic [XLEN-1:0]      era_q, era_d;
  logic [EENT_W-1:0]    eentry_q, eentry_d;
  logic [ECODE_W-1:0]   ecode_q, ecode_d;
  logic [ECODE_W-1:0]   esub_q, esub_d;
  logic                 in_exc_q, in_exc_d;
  logic [XLEN-1:0]      target_q, target_d;

  logic is_idle, accept, take_exc, take_int, take_ertn, csr_wr_en;

  // Accept qualification with exc > int > ertn priority
  assign is_idle   = (state_q == S_IDLE);
  assign accept    = is_idle & wb_valid & (wb_exc | int_req | wb_ertn);
  assign take_exc  = accept & wb_exc;
  assign take_int  = accept & ~wb_exc & int_req;
  assign take_ertn = accept & ~wb_exc & ~int_req;
  assign csr_wr_en = is_idle & ~accept & csr_we;

  // State register and architectural CSR flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      plv_q    <= '0;
      ie_q     <= 1'b0;
      pplv_q   <= '0;
      pie_q    <= 1'b0;
      era_q    <= '0;
      eentry_q <= '0;
      ecode_q  <= '0;
      esub_q   <= '0;
      in_exc_q <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      plv_q    <= plv_d;
      ie_q     <= ie_d;
      pplv_q   <= pplv_d;
      pie_q    <= pie_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      in_exc_q <= in_exc_d;
      target_q <= target_d;
    end
  end

  // Next-state and flush counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // CSR updates: entry/return take precedence, software writes only in a quiet IDLE cycle
  always_comb begin
    plv_d    = plv_q;
    ie_d     = ie_q;
    pplv_d   = pplv_q;
    pie_d    = pie_q;
    era_d    = era_q;
    eentry_d = eentry_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    in_exc_d = in_exc_q;
    target_d = target_q;
    if (take_exc || take_int) begin
      pplv_d   = plv_q;
      pie_d    = ie_q;
      plv_d    = 2'b00;
      ie_d     = 1'b0;
      era_d    = wb_pc;
      ecode_d  = take_exc ? wb_ecode : '0;
      in_exc_d = 1'b1;
      target_d = {eentry_q, 6'b0};
      if (take_int) begin
        esub_d = int_cause;
      end
    end else if (take_ertn) begin
      plv_d    = pplv_q;
      ie_d     = pie_q;
      in_exc_d = 1'b0;
      target_d = era_q;
    end else if (csr_wr_en) begin
      unique case (csr_num)
        CSR_CRMD:   {ie_d, plv_d}   = csr_wdata[2:0];
        CSR_PRMD:   {pie_d, pplv_d} = csr_wdata[2:0];
        CSR_ERA:    era_d           = csr_wdata;
        CSR_EENTRY: eentry_d        = csr_wdata[XLEN-1:6];
        default: ;
      endcase
    end
  end

  // Output decodes
  always_comb begin
    flush          = (state_q == S_FLUSH);
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = (state_q == S_REDIRECT) ? target_q : '0;
    ertn_commit    = take_ertn;
    mie            = ie_q;
    in_exception   = in_exc_q;
    unique case (csr_num)
      CSR_CRMD:   csr_rdata = {29'b0, ie_q, plv_q};
      CSR_PRMD:   csr_rdata = {29'b0, pie_q, pplv_q};
      CSR_ESTAT:  csr_rdata = {10'b0, ecode_q, 16'b0};
      CSR_ERA:    csr_rdata = era_q;
      CSR_ESUB:   csr_rdata = {26'b0, esub_q};
      CSR_EENTRY: csr_rdata = {eentry_q, 6'b0};
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_entry_unit.sv
// Self-checking bench for exc_entry_unit: CSR vector table, directed entry/ertn/reset/flush-length
// sequences, and randomized traffic against a cycle-countdown reference model.
module tb_exc_entry_unit;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_req, wb_valid, wb_exc, wb_ertn, csr_we;
  logic [5:0]  int_cause, wb_ecode;
  logic [31:0] wb_pc, csr_wdata;
  logic [13:0] csr_num;

  logic [31:0] csr_rdata, redirect_pc;
  logic        mie, in_exception, flush, ertn_commit, redirect_valid;
  logic [31:0] csr_rdata1, redirect_pc1, csr_rdata15, redirect_pc15;
  logic        mie1, in_exception1, flush1, ertn_commit1, redirect_valid1;
  logic        mie15, in_exception15, flush15, ertn_commit15, redirect_valid15;

  int errors = 0;
  int checks = 0;

  always #50 clk = ~clk;

  exc_entry_unit u_dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_cause(int_cause),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_ecode(wb_ecode),
    .wb_ertn(wb_ertn), .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .mie(mie), .in_exception(in_exception), .flush(flush),
    .ertn_commit(ertn_commit), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  exc_entry_unit #(.FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_cause(int_cause),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_ecode(wb_ecode),
    .wb_ertn(wb_ertn), .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata1), .mie(mie1), .in_exception(in_exception1), .flush(flush1),
    .ertn_commit(ertn_commit1), .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1)
  );

  exc_entry_unit #(.FLUSH_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_cause(int_cause),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_ecode(wb_ecode),
    .wb_ertn(wb_ertn), .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata15), .mie(mie15), .in_exception(in_exception15), .flush(flush15),
    .ertn_commit(ertn_commit15), .redirect_valid(redirect_valid15), .redirect_pc(redirect_pc15)
  );

  // Reference model: architectural CSRs plus a countdown of busy cycles after an accept
  logic [1:0]  m_plv, m_pplv;
  logic        m_ie, m_pie, m_inexc;
  logic [31:0] m_era, m_eentry, m_target;
  logic [5:0]  m_ecode, m_esub;
  int          m_busy;

  task automatic model_reset();
    m_plv = '0; m_pplv = '0; m_ie = 1'b0; m_pie = 1'b0; m_inexc = 1'b0;
    m_era = '0; m_eentry = '0; m_target = '0; m_ecode = '0; m_esub = '0;
    m_busy = 0;
  endtask

  function automatic logic [31:0] m_read(logic [13:0] n);
    case (n)
      14'h0:   return {29'b0, m_ie, m_plv};
      14'h1:   return {29'b0, m_pie, m_pplv};
      14'h5:   return {10'b0, m_ecode, 16'b0};
      14'h6:   return m_era;
      14'h7:   return {26'b0, m_esub};
      14'hC:   return m_eentry;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit idle;
    bit acc;
    idle = (m_busy == 0);
    acc  = idle && wb_valid && (wb_exc || int_req || wb_ertn);
    if (acc) begin
      if (wb_exc || int_req) begin
        m_pplv = m_plv; m_pie = m_ie; m_plv = 2'b00; m_ie = 1'b0;
        m_era = wb_pc;
        m_ecode = wb_exc ? wb_ecode : 6'h00;
        if (!wb_exc) m_esub = int_cause;
        m_inexc = 1'b1;
        m_target = m_eentry;
      end else begin
        m_plv = m_pplv; m_ie = m_pie; m_inexc = 1'b0;
        m_target = m_era;
      end
      m_busy = N + 1;
    end else begin
      if (m_busy > 0) m_busy = m_busy - 1;
      if (idle && csr_we) begin
        case (csr_num)
          14'h0: {m_ie, m_plv} = csr_wdata[2:0];
          14'h1: {m_pie, m_pplv} = csr_wdata[2:0];
          14'h6: m_era = csr_wdata;
          14'hC: m_eentry = csr_wdata & 32'hFFFF_FFC0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    int_req = 1'b0; wb_valid = 1'b0; wb_exc = 1'b0; wb_ertn = 1'b0; csr_we = 1'b0;
    int_cause = '0; wb_ecode = '0; wb_pc = '0; csr_wdata = '0; csr_num = '0;
  endtask

  // One clock: combinational checks before the edge, registered checks after it
  task automatic tick();
    #1;
    chk("ertn_commit", 32'(ertn_commit),
        32'(m_busy == 0 && wb_valid && !wb_exc && !int_req && wb_ertn));
    chk("csr_rdata", csr_rdata, m_read(csr_num));
    model_step();
    @(posedge clk);
    #1;
    chk("flush", 32'(flush), 32'(m_busy >= 2));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_busy == 1));
    chk("redirect_pc", redirect_pc, (m_busy == 1) ? m_target : 32'h0);
    chk("mie", 32'(mie), 32'(m_ie));
    chk("in_exception", 32'(in_exception), 32'(m_inexc));
  endtask

  task automatic rd(input string name, input logic [13:0] n, input logic [31:0] exp);
    csr_num = n;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  typedef struct {
    logic [13:0] num;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t vecs[7];
  logic [13:0] rnd_nums[8];

  initial begin
    int w1, w15, r1, r15, nred, nred1, nred15;

    clear_in();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flush", 32'(flush), 32'h0);
    chk("reset_redirect", 32'(redirect_valid), 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_mie", 32'(mie), 32'h0);
    chk("reset_in_exc", 32'(in_exception), 32'h0);
    foreach (rnd_nums[i]) rnd_nums[i] = '0;
    rnd_nums = '{14'h0, 14'h1, 14'h5, 14'h6, 14'h7, 14'hC, 14'h2, 14'h3FFF};
    for (int i = 0; i < 6; i++) rd("reset_csr", rnd_nums[i], 32'h0);
    rst_n = 1'b1;

    // CSR write/read-back table
    vecs[0] = '{14'h0,   32'hFFFF_FFFF, 32'h0000_0007};
    vecs[1] = '{14'h1,   32'h0000_0005, 32'h0000_0005};
    vecs[2] = '{14'h6,   32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{14'hC,   32'hFFFF_FFFF, 32'hFFFF_FFC0};
    vecs[4] = '{14'h5,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{14'h7,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{14'h100, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      csr_we = 1'b1; csr_num = vecs[i].num; csr_wdata = vecs[i].wdata;
      tick();
      csr_we = 1'b0;
      rd("csr_table", vecs[i].num, vecs[i].exp);
    end

    // Interrupt entry, with a write dropped in the accept cycle and one dropped in FLUSH
    csr_we = 1'b1; csr_num = 14'hC; csr_wdata = 32'h1C00_8040; tick();
    csr_num = 14'h0; csr_wdata = 32'h4; tick();
    clear_in();
    wb_valid = 1'b1; int_req = 1'b1; int_cause = 6'd11; wb_pc = 32'h1C00_0100;
    csr_we = 1'b1; csr_num = 14'h6; csr_wdata = 32'hDEAD_0000;
    tick();
    clear_in();
    chk("int_flush_t1", 32'(flush), 32'h1);
    csr_we = 1'b1; csr_num = 14'hC; csr_wdata = 32'h0;
    tick();
    clear_in();
    chk("int_flush_t2", 32'(flush), 32'h1);
    tick();
    chk("int_redirect", 32'(redirect_valid), 32'h1);
    chk("int_redirect_pc", redirect_pc, 32'h1C00_8040);
    tick();
    chk("int_redirect_once", 32'(redirect_valid | flush), 32'h0);
    rd("int_era", 14'h6, 32'h1C00_0100);
    rd("int_prmd", 14'h1, 32'h4);
    rd("int_crmd", 14'h0, 32'h0);
    rd("int_estat", 14'h5, 32'h0);
    rd("int_esub", 14'h7, 32'd11);
    rd("int_eentry_kept", 14'hC, 32'h1C00_8040);
    chk("int_in_exc", 32'(in_exception), 32'h1);
    chk("int_mie", 32'(mie), 32'h0);

    // ertn return
    clear_in();
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1C00_8044;
    #1;
    chk("ertn_pulse", 32'(ertn_commit), 32'h1);
    tick();
    clear_in();
    chk("ertn_mie", 32'(mie), 32'h1);
    chk("ertn_in_exc", 32'(in_exception), 32'h0);
    rd("ertn_crmd", 14'h0, 32'h4);
    chk("ertn_commit_off", 32'(ertn_commit), 32'h0);
    tick(); tick();
    chk("ertn_redirect_pc", redirect_pc, 32'h1C00_0100);
    tick();

    // Exception beats simultaneous interrupt
    wb_valid = 1'b1; wb_exc = 1'b1; wb_ecode = 6'h0B; int_req = 1'b1; int_cause = 6'd5;
    wb_pc = 32'h1C00_0200;
    tick();
    clear_in();
    nred = 0;
    for (int k = 0; k < 6; k++) begin
      if (redirect_valid) nred++;
      tick();
    end
    chk("prio_redirects", 32'(nred), 32'h1);
    rd("prio_estat", 14'h5, 32'h000B_0000);
    rd("prio_esub", 14'h7, 32'd11);
    rd("prio_era", 14'h6, 32'h1C00_0200);

    // No action without wb_valid
    int_req = 1'b1; int_cause = 6'd3;
    tick();
    chk("novalid_flush", 32'(flush), 32'h0);
    tick();
    clear_in();
    rd("novalid_esub", 14'h7, 32'd11);

    // Asynchronous reset in the middle of FLUSH
    wb_valid = 1'b1; int_req = 1'b1; int_cause = 6'd9; wb_pc = 32'h1C00_0300;
    tick();
    clear_in();
    chk("rst_pre_flush", 32'(flush), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_redirect", 32'(redirect_valid), 32'h0);
    chk("rst_in_exc", 32'(in_exception), 32'h0);
    rd("rst_era", 14'h6, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    rd("rst_crmd", 14'h0, 32'h0);

    // Flush length for FLUSH_CYCLES = 1 and 15
    wb_valid = 1'b1; int_req = 1'b1; int_cause = 6'd1; wb_pc = 32'h1C00_0400;
    tick();
    clear_in();
    w1 = 0; w15 = 0; r1 = 0; r15 = 0; nred1 = 0; nred15 = 0;
    for (int k = 1; k <= 20; k++) begin
      if (flush1) w1++;
      if (flush15) w15++;
      if (redirect_valid1) begin r1 = k; nred1++; end
      if (redirect_valid15) begin r15 = k; nred15++; end
      tick();
    end
    chk("fl1_width", 32'(w1), 32'd1);
    chk("fl1_redirect_cycle", 32'(r1), 32'd2);
    chk("fl1_redirect_count", 32'(nred1), 32'd1);
    chk("fl15_width", 32'(w15), 32'd15);
    chk("fl15_redirect_cycle", 32'(r15), 32'd16);
    chk("fl15_redirect_count", 32'(nred15), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      wb_valid  = ($urandom_range(0, 3) != 0);
      int_req   = ($urandom_range(0, 3) == 0);
      wb_exc    = ($urandom_range(0, 6) == 0);
      wb_ertn   = ($urandom_range(0, 3) == 0);
      csr_we    = ($urandom_range(0, 2) == 0);
      int_cause = 6'($urandom);
      wb_ecode  = 6'($urandom);
      wb_pc     = $urandom;
      csr_wdata = $urandom;
      csr_num   = rnd_nums[$urandom_range(0, 7)];
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_entry_unit.md
# exc_entry_unit

Exception/interrupt responder at the WB stage of the five-stage pipeline. It consumes the interrupt controller's request (`int_req`/`int_cause`), synchronous exceptions and `ertn` from WB, and owns the CRMD, PRMD, ERA, EENTRY and ESTAT.Ecode state. It drives the pipeline flush, fetch redirect, `in_exception` and the global interrupt enable `mie` back to the interrupt controller.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after entry or return; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `int_req`  in  1  interrupt request from the interrupt controller.
- `int_cause`  in  6  interrupt cause code; captured into ESUB.
- `wb_valid`  in  1  WB stage holds a valid instruction.
- `wb_pc`  in  32  PC of the WB instruction.
- `wb_exc`  in  1  WB instruction raised a synchronous exception.
- `wb_ecode`  in  6  Ecode of that exception.
- `wb_ertn`  in  1  WB instruction is `ertn`.
- `csr_we`  in  1  CSR write from WB.
- `csr_num`  in  14  CSR address.
- `csr_wdata`  in  32  CSR write data.
- `csr_rdata`  out  32  combinational CSR read data.
- `mie`  out  1  CRMD.IE.
- `in_exception`  out  1  handler active.
- `flush`  out  1  pipeline flush.
- `ertn_commit`  out  1  single-cycle pulse when `ertn` is accepted.
- `redirect_valid`  out  1  single-cycle fetch redirect.
- `redirect_pc`  out  32  redirect target.

## Operation
- **CSRs owned by this block**
  - CRMD (0x0): bits [1:0] PLV, bit [2] IE.
  - PRMD (0x1): bits [1:0] PPLV, bit [2] PIE.
  - ESTAT (0x5): reads return {10'b0, Ecode[21:16], 16'b0}; the top level ORs in IS[12:0]. ESTAT writes are ignored here.
  - ERA (0x6): 32 bits, fully writable.
  - EENTRY (0xC): bits [5:0] read as 0 and writes to them are ignored.
  - ESUB (0x7, read-only): {26'b0, last int_cause}.
  - Unmapped addresses read 0.
- **FSM states:** IDLE, FLUSH, REDIRECT.
- **Accept:** occurs only in IDLE with `wb_valid`=1. Priority is `wb_exc` > `int_req` > `wb_ertn`.
- **Exception/interrupt entry** (at the accept edge):
  - PPLV<=PLV, PIE<=IE, PLV<=0, IE<=0.
  - ERA<=`wb_pc`.
  - Ecode<=`wb_exc` ? `wb_ecode` : 6'h00.
  - On an interrupt, ESUB<=`int_cause`.
  - `in_exception`<=1; target<=EENTRY; go to FLUSH.
- **ertn:**
  - PLV<=PPLV, IE<=PIE.
  - `in_exception`<=0; target<=ERA.
  - `ertn_commit` is high combinationally in the accept cycle.
  - Go to FLUSH.
- **FLUSH:** a 4-bit counter loads `FLUSH_CYCLES`-1. `flush`=1 while in this state. When the counter reaches 0, go to REDIRECT.
- **REDIRECT:** `redirect_valid`=1 and `redirect_pc`=target for one cycle, then go to IDLE.
- **CSR writes:**
  - Honoured only in IDLE when no accept occurs in the same cycle. A write in an accept cycle is dropped.
  - All writes during FLUSH/REDIRECT are dropped.
  - A write to EENTRY/ERA in IDLE affects the next entry or return.
- **Ignored inputs:** `int_req`, `wb_exc` and `wb_ertn` are ignored outside IDLE or when `wb_valid`=0.

## Timing
- **Reset values:** all CSRs, state, target and counter reset to 0. Every output resets to 0; `csr_rdata` reads 0 for all CSRs.
- **Accept in cycle T:**
  - CSR updates are visible from T+1.
  - `mie` falls at T+1 on entry and rises at T+1 on `ertn` if PIE=1.
  - `flush` is high for cycles T+1..T+`FLUSH_CYCLES`.
  - `redirect_valid` is high in cycle T+`FLUSH_CYCLES`+1.
  - The next accept is possible at T+`FLUSH_CYCLES`+2.
- **Outputs:** `flush`, `redirect_valid` and `redirect_pc` are registered-state decodes. `redirect_pc` is 0 when `redirect_valid`=0.
- **Simultaneous events:** `wb_exc`+`int_req` in the same cycle is handled as the exception, with Ecode=`wb_exc` code and ESUB unchanged. `int_req`+`wb_ertn` is handled as the interrupt.
- **Reset mid-operation:** an asynchronous `rst_n` assertion in FLUSH/REDIRECT returns to IDLE immediately; `flush`/`redirect_valid` drop without waiting for a clock edge.

## Test plan
- **Interrupt entry:** EENTRY=0x1C008040, CRMD=0x4; `int_req`=1, `int_cause`=11, `wb_pc`=0x1C000100 -> ERA=0x1C000100, PRMD=0x4, CRMD=0x0, Ecode=0, ESUB=11, `flush` high 2 cycles, then `redirect_pc`=0x1C008040 for 1 cycle, `in_exception`=1.
- **ertn:** after the entry above, `wb_ertn`=1 -> `ertn_commit` pulse, CRMD=0x4, `mie`=1 next cycle, `redirect_pc`=0x1C000100, `in_exception`=0.
- **Priority:** `wb_exc`=1 with `wb_ecode`=0x0B together with `int_req`=1 -> Ecode=0x0B, ESUB unchanged, exactly one entry.
- **Masking and dropped writes:** write EENTRY=0xFFFFFFFF -> reads 0xFFFFFFC0. A CSR write in an accept cycle and writes during FLUSH are not applied. `wb_valid`=0 with `int_req`=1 -> no action.
- **Reset mid-flush:** `rst_n` low during FLUSH -> all outputs 0 immediately. After release, IDLE with CRMD=0.
- **Flush length:** `FLUSH_CYCLES`=1 and `FLUSH_CYCLES`=15 -> `flush` width exactly 1 and 15 cycles; redirect immediately after.
